// File: rtl/sprite_pkg.sv
// Shared sprite attribute layout, default geometry and the lane priority encoder
// for the sprite mapper.
package sprite_pkg;

  localparam int HWIDTH_D   = 10;
  localparam int VWIDTH_D   = 10;
  localparam int AWIDTH_D   = 14;
  localparam int NSPRITE_D  = 4;
  localparam int HSIZE_D    = 64;
  localparam int VSIZE_D    = 64;
  localparam int MAXSHIFT_D = 3;
  localparam int SHW_D      = $clog2(MAXSHIFT_D + 1);
  localparam int PRIO_W     = 32;

  typedef struct packed {
    logic                en;
    logic [HWIDTH_D-1:0] hoffset;
    logic [VWIDTH_D-1:0] voffset;
    logic                hflip;
    logic                vflip;
    logic [SHW_D-1:0]    shift;
    logic [AWIDTH_D-1:0] base;
  } sprite_attr_t;

  // Lowest set bit wins; an empty request returns 0.
  function automatic logic [4:0] prio_first(input logic [PRIO_W-1:0] req);
    logic [4:0] idx;
    idx = '0;
    for (int i = PRIO_W - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sprite_lane.sv
// One sprite channel: window test, mirroring and scale clamp on the active
// attributes, registered as pipeline stage 1.
module sprite_lane
  import sprite_pkg::*;
#(
  parameter int HWIDTH   = HWIDTH_D,
  parameter int VWIDTH   = VWIDTH_D,
  parameter int AWIDTH   = AWIDTH_D,
  parameter int HSIZE    = HSIZE_D,
  parameter int VSIZE    = VSIZE_D,
  parameter int MAXSHIFT = MAXSHIFT_D,
  parameter int SHW      = SHW_D,
  parameter int HB       = $clog2(HSIZE),
  parameter int VB       = $clog2(VSIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  sprite_attr_t      attr,
  input  logic [HWIDTH-1:0] hdata,
  input  logic [VWIDTH-1:0] vdata,
  output logic              hit,
  output logic [HB-1:0]     haddr,
  output logic [VB-1:0]     vaddr,
  output logic [SHW-1:0]    shift,
  output logic [AWIDTH-1:0] base
);

  logic [HWIDTH-1:0] dh;
  logic [VWIDTH-1:0] dv;
  logic              in_win;
  logic [SHW:0]      sh_ext;
  logic [SHW-1:0]    sh_clamp;

  // Pixels left of / above the window wrap to large differences and miss.
  assign dh       = hdata - attr.hoffset;
  assign dv       = vdata - attr.voffset;
  assign in_win   = attr.en && (dh < HWIDTH'(HSIZE)) && (dv < VWIDTH'(VSIZE));
  assign sh_ext   = {1'b0, attr.shift};
  assign sh_clamp = (sh_ext > (SHW + 1)'(MAXSHIFT)) ? SHW'(MAXSHIFT) : attr.shift;

  // Inverting the in-window offset is HSIZE-1-dh since the size is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit   <= 1'b0;
      haddr <= '0;
      vaddr <= '0;
      shift <= '0;
      base  <= '0;
    end else begin
      hit   <= in_win;
      haddr <= attr.hflip ? ~dh[HB-1:0] : dh[HB-1:0];
      vaddr <= attr.vflip ? ~dv[VB-1:0] : dv[VB-1:0];
      shift <= sh_clamp;
      base  <= attr.base;
    end
  end

endmodule

// File: rtl/sprite_mapper.sv
// Multi-sprite pixel to ROM address mapper: double-buffered attribute banks,
// per-sprite lanes, then priority select and texel address arithmetic.
module sprite_mapper
  import sprite_pkg::*;
#(
  parameter int HWIDTH   = HWIDTH_D,
  parameter int VWIDTH   = VWIDTH_D,
  parameter int AWIDTH   = AWIDTH_D,
  parameter int NSPRITE  = NSPRITE_D,
  parameter int HSIZE    = HSIZE_D,
  parameter int VSIZE    = VSIZE_D,
  parameter int MAXSHIFT = MAXSHIFT_D,
  localparam int IW      = (NSPRITE > 1) ? $clog2(NSPRITE) : 1,
  localparam int SHW     = $clog2(MAXSHIFT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic              cfg_en,
  input  logic [HWIDTH-1:0] cfg_hoffset,
  input  logic [VWIDTH-1:0] cfg_voffset,
  input  logic              cfg_hflip,
  input  logic              cfg_vflip,
  input  logic [SHW-1:0]    cfg_shift,
  input  logic [AWIDTH-1:0] cfg_base,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [HWIDTH-1:0] hdata,
  input  logic [VWIDTH-1:0] vdata,
  output logic              out_valid,
  output logic              out_hit,
  output logic [IW-1:0]     out_id,
  output logic [AWIDTH-1:0] out_addr
);

  localparam int HB = $clog2(HSIZE);
  localparam int VB = $clog2(VSIZE);
  localparam int PW = HB + VB;

  sprite_attr_t pend [NSPRITE];
  sprite_attr_t act  [NSPRITE];
  sprite_attr_t wr_attr;

  assign wr_attr = '{en:      cfg_en,
                     hoffset: cfg_hoffset,
                     voffset: cfg_voffset,
                     hflip:   cfg_hflip,
                     vflip:   cfg_vflip,
                     shift:   cfg_shift,
                     base:    cfg_base};

  // Commit samples pending before this edge's write, so a simultaneous write
  // waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSPRITE; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NSPRITE; i++) begin
        if (cfg_we && (cfg_idx == IW'(i))) pend[i] <= wr_attr;
        if (frame_start) act[i] <= pend[i];
      end
    end
  end

  logic [NSPRITE-1:0] hit1;
  logic [HB-1:0]      ha1   [NSPRITE];
  logic [VB-1:0]      va1   [NSPRITE];
  logic [SHW-1:0]     sh1   [NSPRITE];
  logic [AWIDTH-1:0]  base1 [NSPRITE];
  logic               v1;

  for (genvar g = 0; g < NSPRITE; g++) begin : g_lane
    sprite_lane #(
      .HWIDTH  (HWIDTH),
      .VWIDTH  (VWIDTH),
      .AWIDTH  (AWIDTH),
      .HSIZE   (HSIZE),
      .VSIZE   (VSIZE),
      .MAXSHIFT(MAXSHIFT),
      .SHW     (SHW)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .attr (act[g]),
      .hdata(hdata),
      .vdata(vdata),
      .hit  (hit1[g]),
      .haddr(ha1[g]),
      .vaddr(va1[g]),
      .shift(sh1[g]),
      .base (base1[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= in_valid;
  end

  logic [PRIO_W-1:0] req;
  logic [IW-1:0]     win;
  logic              any_hit;
  logic [SHW-1:0]    sel_s;
  logic [HB-1:0]     hs;
  logic [VB-1:0]     vs;
  logic [PW-1:0]     off;
  logic [AWIDTH-1:0] addr_n;

  assign req     = PRIO_W'(hit1);
  assign win     = IW'(prio_first(req));
  assign any_hit = |hit1;

  // Row stride is HSIZE>>s texels, so the row term is a left shift by HB-s.
  always_comb begin
    sel_s  = sh1[win];
    hs     = ha1[win] >> sel_s;
    vs     = va1[win] >> sel_s;
    off    = (PW'(vs) << (HB - int'(sel_s))) + PW'(hs);
    addr_n = '0;
    if (any_hit) addr_n = base1[win] + AWIDTH'(off);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_id    <= '0;
      out_addr  <= '0;
    end else begin
      out_valid <= v1;
      out_hit   <= any_hit;
      out_id    <= any_hit ? win : '0;
      out_addr  <= addr_n;
    end
  end

endmodule

// File: tb/tb_sprite_mapper.sv
// Scoreboard bench for sprite_mapper: expected results are queued with their
// due cycle when a pixel is driven and checked when the output appears.
module tb_sprite_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [9:0]  cfg_hoffset;
  logic [9:0]  cfg_voffset;
  logic        cfg_hflip;
  logic        cfg_vflip;
  logic [1:0]  cfg_shift;
  logic [13:0] cfg_base;
  logic        frame_start;
  logic        in_valid;
  logic [9:0]  hdata;
  logic [9:0]  vdata;
  logic        out_valid;
  logic        out_hit;
  logic [1:0]  out_id;
  logic [13:0] out_addr;

  sprite_mapper dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_hoffset(cfg_hoffset),
    .cfg_voffset(cfg_voffset),
    .cfg_hflip  (cfg_hflip),
    .cfg_vflip  (cfg_vflip),
    .cfg_shift  (cfg_shift),
    .cfg_base   (cfg_base),
    .frame_start(frame_start),
    .in_valid   (in_valid),
    .hdata      (hdata),
    .vdata      (vdata),
    .out_valid  (out_valid),
    .out_hit    (out_hit),
    .out_id     (out_id),
    .out_addr   (out_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        hit;
    logic [1:0]  id;
    logic [13:0] addr;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  int m_en   [4];
  int m_hoff [4];
  int m_voff [4];
  int m_hf   [4];
  int m_vf   [4];
  int m_sh   [4];
  int m_base [4];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_hit !== e.hit || out_id !== e.id || out_addr !== e.addr) begin
        bad++;
        $display("FAIL pixel cyc=%0d got v=%b hit=%b id=%0d addr=%0d want v=1 hit=%b id=%0d addr=%0d",
                 cyc, out_valid, out_hit, out_id, out_addr, e.hit, e.id, e.addr);
      end
    end else begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stray_valid cyc=%0d got out_valid=%b want 0", cyc, out_valid);
      end
    end
  end

  task automatic cfg(input int idx, input int en, input int hoff, input int voff,
                     input int hf, input int vf, input int sh, input int base);
    @(negedge clk);
    in_valid    = 1'b0;
    cfg_we      = 1'b1;
    cfg_idx     = 2'(idx);
    cfg_en      = 1'(en);
    cfg_hoffset = 10'(hoff);
    cfg_voffset = 10'(voff);
    cfg_hflip   = 1'(hf);
    cfg_vflip   = 1'(vf);
    cfg_shift   = 2'(sh);
    cfg_base    = 14'(base);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    in_valid    = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pix(input int h, input int v, input logic hit, input int id, input int addr);
    @(negedge clk);
    in_valid = 1'b1;
    hdata    = 10'(h);
    vdata    = 10'(v);
    q.push_back('{cyc + 2, hit, 2'(id), 14'(addr)});
  endtask

  task automatic flush();
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic model(input int h, input int v, output logic hit, output int id, output int addr);
    int dh, dv, ha, va, s, a;
    hit  = 1'b0;
    id   = 0;
    addr = 0;
    for (int i = 3; i >= 0; i--) begin
      dh = (h - m_hoff[i]) & 1023;
      dv = (v - m_voff[i]) & 1023;
      if (m_en[i] != 0 && dh < 64 && dv < 64) begin
        ha   = (m_hf[i] != 0) ? 63 - dh : dh;
        va   = (m_vf[i] != 0) ? 63 - dv : dv;
        s    = (m_sh[i] > 3) ? 3 : m_sh[i];
        a    = m_base[i] + (va >> s) * (64 >> s) + (ha >> s);
        hit  = 1'b1;
        id   = i;
        addr = a % 16384;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (out_hit !== 1'b0)   begin bad++; $display("FAIL reset_hit got %b want 0", out_hit); end
    if (out_id !== 2'd0)    begin bad++; $display("FAIL reset_id got %0d want 0", out_id); end
    if (out_addr !== 14'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", out_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    cfg(0, 1, 100, 50, 0, 0, 0, 0);
    commit();
    pix(110, 60, 1, 0, 650);
    flush();
    cfg(0, 1, 100, 50, 1, 0, 0, 0);
    commit();
    pix(110, 60, 1, 0, 693);
    flush();
    cfg(0, 1, 100, 50, 0, 1, 0, 0);
    commit();
    pix(110, 60, 1, 0, 3402);
    flush();
  endtask

  task automatic test_scale();
    cfg(0, 1, 100, 50, 0, 0, 1, 4096);
    commit();
    pix(110, 60, 1, 0, 4261);
    flush();
    cfg(0, 1, 100, 50, 0, 0, 3, 4096);
    commit();
    pix(110, 60, 1, 0, 4096 + 8 + 1);
    flush();
  endtask

  task automatic test_bounds();
    cfg(0, 1, 100, 50, 0, 0, 0, 0);
    commit();
    pix(99, 60, 0, 0, 0);
    pix(164, 60, 0, 0, 0);
    pix(163, 113, 1, 0, 4095);
    pix(100, 50, 1, 0, 0);
    pix(110, 49, 0, 0, 0);
    pix(110, 114, 0, 0, 0);
    flush();
  endtask

  task automatic test_priority();
    cfg(1, 1, 100, 50, 0, 0, 0, 8192);
    commit();
    pix(110, 60, 1, 0, 650);
    flush();
    cfg(0, 0, 100, 50, 0, 0, 0, 0);
    commit();
    pix(110, 60, 1, 1, 8192 + 650);
    flush();
    cfg(1, 0, 100, 50, 0, 0, 0, 8192);
    cfg(0, 1, 100, 50, 0, 0, 0, 0);
    commit();
    pix(110, 60, 1, 0, 650);
    flush();
  endtask

  task automatic test_commit();
    cfg(0, 1, 200, 50, 0, 0, 0, 0);
    pix(110, 60, 1, 0, 650);
    flush();
    // Write hoffset=300 while committing: active takes pending (200), not 300.
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_idx     = 2'd0;
    cfg_en      = 1'b1;
    cfg_hoffset = 10'd300;
    cfg_voffset = 10'd50;
    cfg_hflip   = 1'b0;
    cfg_vflip   = 1'b0;
    cfg_shift   = 2'd0;
    cfg_base    = 14'd0;
    frame_start = 1'b1;
    in_valid    = 1'b1;
    hdata       = 10'd110;
    vdata       = 10'd60;
    q.push_back('{cyc + 2, 1'b1, 2'd0, 14'd650});
    @(negedge clk);
    cfg_we      = 1'b0;
    frame_start = 1'b0;
    q.push_back('{cyc + 2, 1'b0, 2'd0, 14'd0});
    flush();
    pix(210, 60, 1, 0, 650);
    pix(310, 60, 0, 0, 0);
    flush();
    commit();
    pix(310, 60, 1, 0, 650);
    pix(210, 60, 0, 0, 0);
    flush();
  endtask

  task automatic test_back_to_back();
    logic eh;
    int   ei, ea, h, v;
    cfg(0, 1, 100, 50, 0, 0, 0, 0);
    cfg(2, 1, 130, 70, 1, 0, 1, 1000);
    commit();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0; m_hoff[i] = 0; m_voff[i] = 0; m_hf[i] = 0; m_vf[i] = 0; m_sh[i] = 0; m_base[i] = 0;
    end
    m_en[0] = 1; m_hoff[0] = 100; m_voff[0] = 50;
    m_en[2] = 1; m_hoff[2] = 130; m_voff[2] = 70; m_hf[2] = 1; m_sh[2] = 1; m_base[2] = 1000;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end else begin
        h = int'($urandom_range(90, 200));
        v = int'($urandom_range(40, 140));
        model(h, v, eh, ei, ea);
        pix(h, v, eh, ei, ea);
      end
    end
    flush();
  endtask

  task automatic test_midreset();
    pix(110, 60, 1, 0, 650);
    @(negedge clk);
    hdata    = 10'd120;
    vdata    = 10'd70;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b1;
    hdata    = 10'd130;
    in_valid = 1'b1;
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    if (out_hit !== 1'b0)   begin bad++; $display("FAIL midrst_hit got %b want 0", out_hit); end
    if (out_id !== 2'd0)    begin bad++; $display("FAIL midrst_id got %0d want 0", out_id); end
    if (out_addr !== 14'd0) begin bad++; $display("FAIL midrst_addr got %0d want 0", out_addr); end
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    pix(110, 60, 0, 0, 0);
    flush();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_hoffset = '0; cfg_voffset = '0;
    cfg_hflip = 1'b0; cfg_vflip = 1'b0; cfg_shift = '0; cfg_base = '0; frame_start = 1'b0;
    in_valid = 1'b0; hdata = '0; vdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_scale();
    test_bounds();
    test_priority();
    test_commit();
    test_back_to_back();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got cyc=%0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_mapper.md
# sprite_mapper

Pipelined multi-sprite coordinate-to-ROM address mapper for the video path. Each cycle it takes one screen pixel coordinate and checks it against up to NSPRITE sprite windows, using per-sprite offset, flip, texel scale and ROM base. It returns the ROM address and index of the highest-priority sprite covering the pixel, two cycles later. Sprite attributes are double-buffered and committed on a frame boundary so that mid-frame updates never tear.

## Interface
- HWIDTH, 10: horizontal coordinate width
- VWIDTH, 10: vertical coordinate width
- AWIDTH, 14: sprite ROM address width
- NSPRITE, 4: number of sprite channels (≥1)
- HSIZE, 64: on-screen sprite width in pixels (power of two)
- VSIZE, 64: on-screen sprite height in pixels (power of two)
- MAXSHIFT, 3: maximum texel scale shift
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write pending attributes of sprite cfg_idx
- cfg_idx  in  $clog2(NSPRITE)  sprite index; out-of-range values ignore the write
- cfg_en  in  1  sprite enable
- cfg_hoffset  in  HWIDTH  left screen x
- cfg_voffset  in  VWIDTH  top screen y
- cfg_hflip, cfg_vflip  in  1 each  mirror flags
- cfg_shift  in  $clog2(MAXSHIFT+1)  texel scale; one texel = 2^shift pixels
- cfg_base  in  AWIDTH  ROM base address of the sprite image
- frame_start  in  1  commit pending attributes to active
- in_valid  in  1  pixel coordinate valid
- hdata  in  HWIDTH  pixel x
- vdata  in  VWIDTH  pixel y
- out_valid  out  1  result valid (in_valid delayed 2)
- out_hit  out  1  some enabled sprite covers the pixel
- out_id  out  $clog2(NSPRITE)  winning sprite index
- out_addr  out  AWIDTH  ROM address for the winner

## Operation
- There are two attribute banks, pending and active. Reset clears both: en=0, all other fields 0.
- cfg_we writes the pending bank only.
- frame_start copies all pending entries to active in one cycle.
- If cfg_we and frame_start occur together, the commit copies the pre-write pending value. The new write lands in pending and takes effect at the next frame_start.
- Lane i arithmetic, all modulo 2^HWIDTH / 2^VWIDTH:
  - dh = hdata − hoffset, dv = vdata − voffset.
  - in_i = en & (dh < HSIZE) & (dv < VSIZE). Negative differences wrap to large values and therefore miss.
- Flip: haddr = hflip ? HSIZE−1−dh : dh; vaddr likewise with VSIZE−1−dv.
- Scale: s = min(shift, MAXSHIFT); texel width TW = HSIZE>>s.
- Address: addr_i = base + (vaddr>>s)·TW + (haddr>>s), truncated to AWIDTH. Base + offset wrapping past 2^AWIDTH wraps silently.
- Priority: the lowest-index lane with in_i wins.
- No hit: out_hit=0, out_id=0, out_addr=0.
- Lanes read the active bank only. A commit affects pixels entering stage 1 on the cycle after frame_start.
- There is no backpressure. in_valid=0 produces a bubble, and all outputs are still computed. Downstream qualifies results with out_valid.

## Timing
- Stage 1 (register): per-lane flipped haddr/vaddr, in_i, shift, base.
- Stage 2 (register): priority select and address multiply-add.
- Latency is exactly 2 cycles, with throughput of 1 pixel per cycle.
- All outputs reset to 0, and pipeline valid bits clear in the reset cycle. Reset mid-stream drops in-flight pixels; out_valid=0 for the 2 cycles after rst deasserts unless new in_valid arrives.
- Commit takes 1 cycle: active is updated on the clk edge where frame_start=1.

## Structure
- Package sprite_pkg:
  - sprite_attr_t struct {en, hoffset, voffset, hflip, vflip, shift, base}.
  - Default sizes as localparams.
  - Priority-encode function.
- Sub-module sprite_lane: one sprite's stage-1 subtract/flip/range check and registered outputs, instantiated NSPRITE times.
- The top level holds both banks, the commit logic, the stage-2 select and the address arithmetic.

## Test plan
All cases use default parameters. Sprite0 is: en=1, hoffset=100, voffset=50, shift=0, base=0, committed.
- Pixel (110,60) → after 2 cycles out_valid=1, hit=1, id=0, addr=650. With hflip=1 → addr=693. With vflip=1 → addr=53·64+10=3402.
- shift=1, base=4096, pixel (110,60) → addr=4096+5·32+5=4261. shift=3 equals shift=7 (clamped).
- Pixel (99,60) → hit=0, addr=0. Pixel (164,60) → hit=0. Pixel (163,113) → hit=1, addr=63·64+63=4095.
- Sprite1 at the same window with base=8192 → id=0 wins. Disabling sprite0 → id=1, addr=8192+650.
- Rewrite sprite0 hoffset=200 with frame_start low → old mapping persists. Assert cfg_we and frame_start together → still old mapping. A further frame_start → (210,60) gives addr=650.
- Assert rst while 2 pixels are in flight → out_valid, out_hit, out_id, out_addr all 0 on the next cycle. Attributes are cleared, so (110,60) misses.
